multi_port_fifo: RTL and testbench

Parametrised circular FIFO that accepts PAR_WRITE words per write beat and delivers PAR_READ words per read beat. Both sides use valid/ready handshakes, and the FIFO reports an exact occupancy count. It replaces the fixed-step counter/buffer datapath in front of the processing pipeline. It adds four things that datapath lacks: correct full/empty for any lane counts, arbitrary depth with modulo wrap, an almost-full threshold, and a compile-time flush.

---
 rtl/multi_port_fifo.sv | 120 ++++++++++++
 tb/tb_multi_port_fifo.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_port_fifo.sv
// Circular FIFO taking PAR_WRITE words per write beat and delivering PAR_READ words per read beat.
// Define MULTI_PORT_FIFO_FLUSH_EN to add a synchronous flush input.
module multi_port_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int PAR_WRITE   = 2,
  parameter int PAR_READ    = 3,
  parameter int AFULL_LEVEL = DEPTH - PAR_WRITE
) (
  input  logic                             clk,
  input  logic                             rst,
`ifdef MULTI_PORT_FIFO_FLUSH_EN
  input  logic                             flush,
`endif
  input  logic [PAR_WRITE*DATA_WIDTH-1:0]  wr_data,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  output logic [PAR_READ*DATA_WIDTH-1:0]   rd_data,
  output logic                             rd_valid,
  input  logic                             rd_ready,
  output logic [$clog2(DEPTH+1)-1:0]       level,
  output logic                             full,
  output logic                             empty,
  output logic                             almost_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W:0]   DEPTH_P  = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   PW_P     = (PTR_W + 1)'(PAR_WRITE);
  localparam logic [PTR_W:0]   PR_P     = (PTR_W + 1)'(PAR_READ);
  localparam logic [LVL_W-1:0] PW_L     = LVL_W'(PAR_WRITE);
  localparam logic [LVL_W-1:0] PR_L     = LVL_W'(PAR_READ);
  localparam logic [LVL_W-1:0] WR_MAX_L = LVL_W'(DEPTH - PAR_WRITE);
  localparam logic [LVL_W-1:0] AF_L     = LVL_W'(AFULL_LEVEL);

  // base + inc never reaches 2*DEPTH, so one conditional subtract wraps it.
  function automatic logic [PTR_W-1:0] add_wrap(input logic [PTR_W-1:0] base,
                                                input logic [PTR_W:0]   inc);
    logic [PTR_W:0] sum;
    sum = {1'b0, base} + inc;
    if (sum >= DEPTH_P) sum = sum - DEPTH_P;
    return sum[PTR_W-1:0];
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]      wptr_q, wptr_d;
  logic [PTR_W-1:0]      rptr_q, rptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  flush_req;
  logic                  wfire;
  logic                  rfire;

`ifdef MULTI_PORT_FIFO_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  // Handshake flags come from registered occupancy only.
  assign wr_ready    = (level_q <= WR_MAX_L);
  assign rd_valid    = (level_q >= PR_L);
  assign full        = !wr_ready;
  assign empty       = (level_q == '0);
  assign almost_full = (level_q >= AF_L);
  assign level       = level_q;

  assign wfire = wr_valid && wr_ready && !flush_req;
  assign rfire = rd_ready && rd_valid && !flush_req;

  always_comb begin : next_state
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush_req) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (wfire) begin
        for (int i = 0; i < PAR_WRITE; i++) begin
          mem_d[add_wrap(wptr_q, (PTR_W + 1)'(i))] = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
        wptr_d = add_wrap(wptr_q, PW_P);
      end
      if (rfire) begin
        rptr_d = add_wrap(rptr_q, PR_P);
      end
      level_d = level_q + (wfire ? PW_L : '0) - (rfire ? PR_L : '0);
    end
  end

  always_comb begin : read_lanes
    rd_data = '0;
    for (int j = 0; j < PAR_READ; j++) begin
      rd_data[j*DATA_WIDTH +: DATA_WIDTH] = mem_q[add_wrap(rptr_q, (PTR_W + 1)'(j))];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: storage is reset so show-ahead rd_data is defined (zero) right after reset.
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

endmodule

// File: tb/tb_multi_port_fifo.sv
// Randomised and directed bench for multi_port_fifo against a queue-based model.
// Define MULTI_PORT_FIFO_FLUSH_EN to also exercise flush.
module tb_multi_port_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int PW    = 2;
  localparam int PR    = 3;
  localparam int AFULL = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [15:0]   wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [23:0]   rd_data;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [4:0]    level;
  logic          full;
  logic          empty;
  logic          almost_full;
`ifdef MULTI_PORT_FIFO_FLUSH_EN
  logic          flush = 1'b0;
`endif

  always #5 clk = ~clk;

  multi_port_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .PAR_WRITE  (PW),
    .PAR_READ   (PR),
    .AFULL_LEVEL(AFULL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef MULTI_PORT_FIFO_FLUSH_EN
    .flush      (flush),
`endif
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .level      (level),
    .full       (full),
    .empty      (empty),
    .almost_full(almost_full)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  model_q[$];
  logic [23:0] last_rd;
  bit          wf;
  bit          rf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected outputs follow directly from how many words the model holds.
  task automatic check_outputs();
    int sz;
    sz = model_q.size();
    check("level",       32'(level),       32'(sz));
    check("empty",       32'(empty),       32'(sz == 0));
    check("full",        32'(full),        32'((DEPTH - sz) < PW));
    check("wr_ready",    32'(wr_ready),    32'((DEPTH - sz) >= PW));
    check("rd_valid",    32'(rd_valid),    32'(sz >= PR));
    check("almost_full", 32'(almost_full), 32'(sz >= AFULL));
    if (sz >= PR) check("rd_data", 32'(rd_data), 32'({model_q[2], model_q[1], model_q[0]}));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_level"},    32'(level),       32'd0);
    check({tag, "_empty"},    32'(empty),       32'd1);
    check({tag, "_full"},     32'(full),        32'd0);
    check({tag, "_wr_ready"}, 32'(wr_ready),    32'd1);
    check({tag, "_rd_valid"}, 32'(rd_valid),    32'd0);
    check({tag, "_afull"},    32'(almost_full), 32'd0);
    check({tag, "_rd_data"},  32'(rd_data),     32'd0);
  endtask

  // Called 1 time unit after a rising edge; asserts rst between edges.
  task automatic do_reset(input string tag);
    #2 rst = 1'b0;
    #1 check_reset_state(tag);
    model_q.delete();
    @(negedge clk);
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One clock: drive, check at the falling edge, then update the model at the rising edge.
  task automatic step(input logic wv, input logic [15:0] wd, input logic rr,
                      output bit wfo, output bit rfo);
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    @(negedge clk);
    check_outputs();
    last_rd = rd_data;
    wfo = wv && ((DEPTH - model_q.size()) >= PW);
    rfo = rr && (model_q.size() >= PR);
`ifdef MULTI_PORT_FIFO_FLUSH_EN
    if (flush) begin
      wfo = 1'b0;
      rfo = 1'b0;
    end
`endif
    @(posedge clk);
    #1;
`ifdef MULTI_PORT_FIFO_FLUSH_EN
    if (flush) model_q.delete();
`endif
    if (rfo) repeat (PR) void'(model_q.pop_front());
    if (wfo) begin
      model_q.push_back(wd[7:0]);
      model_q.push_back(wd[15:8]);
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wbyte;
    int seq_next;

    // Reset and first fill/read
    do_reset("reset");
    step(1'b1, 16'h0201, 1'b0, wf, rf);
    step(1'b1, 16'h0403, 1'b0, wf, rf);
    check("fill_level", 32'(level), 32'd4);
    check("fill_rd_valid", 32'(rd_valid), 32'd1);
    step(1'b0, 16'h0000, 1'b1, wf, rf);
    check("fill_rd_data", 32'(last_rd), 32'h030201);
    check("tail_level", 32'(level), 32'd1);
    check("tail_rd_valid", 32'(rd_valid), 32'd0);
    check("tail_empty", 32'(empty), 32'd0);

    // Fill to full, then an ignored write
    do_reset("reset_full");
    for (int i = 0; i < 8; i++) step(1'b1, 16'($urandom), 1'b0, wf, rf);
    check("full_level", 32'(level), 32'd16);
    check("full_flag", 32'(full), 32'd1);
    step(1'b1, 16'hBEEF, 1'b0, wf, rf);
    check("full_ignored_level", 32'(level), 32'd16);

    // Simultaneous write and read
    do_reset("reset_sim");
    for (int i = 0; i < 4; i++) step(1'b1, 16'($urandom), 1'b0, wf, rf);
    step(1'b0, 16'h0000, 1'b1, wf, rf);
    check("sim_level5", 32'(level), 32'd5);
    step(1'b1, 16'($urandom), 1'b1, wf, rf);
    check("sim_level4", 32'(level), 32'd4);
    step(1'b0, 16'h0000, 1'b1, wf, rf);
    for (int i = 0; i < 7; i++) step(1'b1, 16'($urandom), 1'b0, wf, rf);
    check("sim_level15", 32'(level), 32'd15);
    check("sim_wr_ready15", 32'(wr_ready), 32'd0);
    step(1'b1, 16'($urandom), 1'b1, wf, rf);
    check("sim_level12", 32'(level), 32'd12);
    check("sim_wr_ready12", 32'(wr_ready), 32'd1);

    // Incrementing stream across pointer wraps
    do_reset("reset_wrap");
    wbyte    = 0;
    seq_next = 0;
    for (int c = 0; c < 200 && seq_next < 63; c++) begin
      step(wbyte < 64, {8'(wbyte + 1), 8'(wbyte)}, 1'b1, wf, rf);
      if (wf) wbyte += 2;
      if (rf) begin
        for (int j = 0; j < PR; j++) begin
          check("wrap_seq", 32'(last_rd[j*8 +: 8]), 32'(8'(seq_next)));
          seq_next++;
        end
      end
    end
    check("wrap_done", 32'(seq_next), 32'd63);
    check("wrap_left", 32'(level), 32'd1);

    // Random traffic
    do_reset("reset_rand");
    for (int c = 0; c < 400; c++) begin
      step(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 2) != 0), wf, rf);
    end

    // Reset mid-stream with a write offered
    do_reset("reset_mid_pre");
    for (int i = 0; i < 6; i++) step(1'b1, 16'($urandom), 1'b0, wf, rf);
    step(1'b0, 16'h0000, 1'b1, wf, rf);
    check("mid_level9", 32'(level), 32'd9);
    wr_valid = 1'b1;
    wr_data  = 16'h5A5A;
    do_reset("reset_mid");
    step(1'b0, 16'h0000, 1'b0, wf, rf);

`ifdef MULTI_PORT_FIFO_FLUSH_EN
    for (int i = 0; i < 6; i++) step(1'b1, 16'($urandom), 1'b0, wf, rf);
    step(1'b0, 16'h0000, 1'b1, wf, rf);
    check("flush_pre_level", 32'(level), 32'd9);
    flush = 1'b1;
    step(1'b1, 16'hA5A5, 1'b0, wf, rf);
    flush = 1'b0;
    check("flush_level", 32'(level), 32'd0);
    check("flush_empty", 32'(empty), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 16'($urandom), 1'b1, wf, rf);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
